// File: rtl/hashin_arb_pkg.sv
// obtc_pkg: shared types and constants for the hashin arbiter
package obtc_pkg;
  typedef enum logic {ST_OFFER, ST_FRAME} arb_state_e;
  localparam int          FRAME_BEATS_DEF = 11;
  localparam logic [63:0] HASHIN_PAD      = 64'h8000000000000280;
endpackage

// File: rtl/hashin_arb_if.sv
// hashin_arb_if: lane-side and shared-FIFO signals of the hashin arbiter
interface hashin_arb_if #(parameter int NUM_LANES = 4);
  logic [NUM_LANES-1:0]       lane_hashin_we;
  logic [NUM_LANES-1:0][63:0] lane_hashin_din;
  logic [NUM_LANES-1:0]       lane_nonce_we;
  logic [NUM_LANES-1:0][31:0] lane_nonce_din;
  logic [NUM_LANES-1:0]       lane_full;
  logic                       hashin_fifo_in_we;
  logic [63:0]                hashin_fifo_in_din;
  logic                       hashin_fifo_in_full;
  logic                       nonce_fifo_we;
  logic [31:0]                nonce_fifo_din;
  logic                       nonce_fifo_full;
  logic [3:0]                 nonce_lane_id;
  logic [NUM_LANES-1:0]       proto_err;
  modport slave (
    input  lane_hashin_we, lane_hashin_din, lane_nonce_we, lane_nonce_din,
           hashin_fifo_in_full, nonce_fifo_full,
    output lane_full, hashin_fifo_in_we, hashin_fifo_in_din, nonce_fifo_we,
           nonce_fifo_din, nonce_lane_id, proto_err
  );
  modport master (
    output lane_hashin_we, lane_hashin_din, lane_nonce_we, lane_nonce_din,
           hashin_fifo_in_full, nonce_fifo_full,
    input  lane_full, hashin_fifo_in_we, hashin_fifo_in_din, nonce_fifo_we,
           nonce_fifo_din, nonce_lane_id, proto_err
  );
endinterface

// File: rtl/hashin_arb_rr_next.sv
// rr_next: round-robin successor of a lane index, (g+1) mod N
module rr_next #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [W-1:0] i_g,
  output logic [W-1:0] o_g
);
  always_comb o_g = (i_g == W'(N - 1)) ? '0 : i_g + 1'b1;
endmodule

// File: rtl/hashin_arb.sv
// hashin_arb: grants one nonce lane at a time onto the shared hashin/nonce FIFOs, whole frames only.
// Defining HASHIN_ARB_STATS_EN adds frame_cnt and timeout_cnt outputs.
module hashin_arb import obtc_pkg::*; #(
  parameter int NUM_LANES     = 4,
  parameter int FRAME_BEATS   = FRAME_BEATS_DEF,
  parameter int OFFER_TIMEOUT = 4
) (
  input logic         clk,
  input logic         rst_n,
  hashin_arb_if.slave bus
`ifdef HASHIN_ARB_STATS_EN
  ,
  output logic [31:0] frame_cnt,
  output logic [15:0] timeout_cnt
`endif
);
  localparam int GW = $clog2(NUM_LANES);
  localparam int BW = $clog2(FRAME_BEATS + 1);
  localparam int TW = $clog2(OFFER_TIMEOUT + 1);
  arb_state_e           r_state, w_state_nx;
  logic [GW-1:0]        r_g, w_g_nx, w_g_inc;
  logic [BW-1:0]        r_beat, w_beat_nx;
  logic [TW-1:0]        r_tmo, w_tmo_nx;
  logic [NUM_LANES-1:0] r_err, w_onehot, w_full, w_err_set;
  logic                 w_offer, w_hwe, w_nwe, w_busy, w_gfull, w_acc_h, w_acc_n, w_done, w_rot;
  rr_next #(.N(NUM_LANES), .W(GW)) u_rr (.i_g(r_g), .o_g(w_g_inc));
  // A frame opens only when lane g delivers pad beat and nonce together; afterwards only hashin beats count.
  always_comb begin
    w_offer   = r_state == ST_OFFER;
    w_hwe     = bus.lane_hashin_we[r_g];
    w_nwe     = bus.lane_nonce_we[r_g];
    w_busy    = bus.hashin_fifo_in_full | bus.nonce_fifo_full;
    w_gfull   = w_offer ? w_busy : bus.hashin_fifo_in_full;
    w_onehot  = NUM_LANES'(1) << r_g;
    w_full    = !rst_n ? '1 : (w_gfull ? '1 : ~w_onehot);
    w_acc_h   = rst_n & w_hwe & ~w_gfull & (~w_offer | w_nwe);
    w_acc_n   = w_acc_h & w_offer;
    w_done    = w_acc_h && (r_beat + 1'b1) == BW'(FRAME_BEATS);
    w_rot     = rst_n && w_offer && !w_hwe && !w_nwe && !w_busy && (r_tmo + 1'b1) == TW'(OFFER_TIMEOUT);
    w_err_set = !rst_n ? '0 : (((bus.lane_hashin_we | bus.lane_nonce_we) & w_full) |
                               ((w_offer ? w_hwe ^ w_nwe : w_nwe) ? w_onehot : '0));
  end
  always_comb begin
    w_state_nx = r_state;
    w_g_nx     = r_g;
    w_beat_nx  = r_beat;
    w_tmo_nx   = r_tmo;
    if (w_done) begin
      w_state_nx = ST_OFFER;
      w_g_nx     = w_g_inc;
      w_beat_nx  = '0;
      w_tmo_nx   = '0;
    end else if (w_acc_h) begin
      w_state_nx = ST_FRAME;
      w_beat_nx  = r_beat + 1'b1;
      w_tmo_nx   = '0;
    end else if (w_rot) begin
      w_g_nx   = w_g_inc;
      w_tmo_nx = '0;
    end else if (w_offer) begin
      w_tmo_nx = (w_hwe | w_nwe) ? '0 : (w_busy ? r_tmo : r_tmo + 1'b1);
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_OFFER;
      r_g     <= '0;
      r_beat  <= '0;
      r_tmo   <= '0;
      r_err   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_g     <= w_g_nx;
      r_beat  <= w_beat_nx;
      r_tmo   <= w_tmo_nx;
      r_err   <= r_err | w_err_set;
    end
  end
  assign bus.lane_full          = w_full;
  assign bus.hashin_fifo_in_we  = w_acc_h;
  assign bus.hashin_fifo_in_din = w_acc_h ? bus.lane_hashin_din[r_g] : '0;
  assign bus.nonce_fifo_we      = w_acc_n;
  assign bus.nonce_fifo_din     = w_acc_n ? bus.lane_nonce_din[r_g] : '0;
  assign bus.nonce_lane_id      = w_acc_n ? 4'(r_g) : '0;
  assign bus.proto_err          = r_err;
`ifdef HASHIN_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_cnt   <= '0;
      timeout_cnt <= '0;
    end else begin
      frame_cnt   <= frame_cnt + 32'(w_done);
      timeout_cnt <= (w_rot && timeout_cnt != 16'hFFFF) ? timeout_cnt + 1'b1 : timeout_cnt;
    end
  end
`endif
endmodule

// File: tb/tb_hashin_arb.sv
// tb_hashin_arb: directed scenarios plus randomized traffic checked against a cycle-level reference model
module tb_hashin_arb;
  import obtc_pkg::*;
  localparam int NL = 4, FB = 11, TO = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  hashin_arb_if #(.NUM_LANES(NL)) bus ();
`ifdef HASHIN_ARB_STATS_EN
  logic [31:0] frame_cnt;
  logic [15:0] timeout_cnt;
`endif
  hashin_arb #(.NUM_LANES(NL), .FRAME_BEATS(FB), .OFFER_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
`ifdef HASHIN_ARB_STATS_EN
    , .frame_cnt(frame_cnt), .timeout_cnt(timeout_cnt)
`endif
  );
  int n_chk = 0, n_err = 0;
  int m_g, m_beats, m_idle, m_frames, m_tmos;
  bit m_frm;
  logic [NL-1:0] m_err;
  int lane_beat [NL];
  int n_hw, n_nw, last_id, wait_cyc;
  logic [31:0] last_nonce;
  int order [$];
  logic [NL-1:0] cap_lf, cap_err;
  bit rnd_nonce;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic clr();
    n_hw = 0;
    n_nw = 0;
    last_id = -1;
    last_nonce = '0;
    order.delete();
  endtask
  // Lanes behave like real producers: they write only when their lane_full bit is low.
  task automatic step(input logic [NL-1:0] want, gh, gn, input logic hf, nf, rst);
    logic [NL-1:0] ef, lh, hw, nw;
    logic eh, en;
    @(negedge clk);
    rst_n = rst;
    bus.hashin_fifo_in_full = hf;
    bus.nonce_fifo_full = nf;
    #1;
    for (int i = 0; i < NL; i++) begin
      lh[i] = want[i] & ~bus.lane_full[i];
      bus.lane_hashin_we[i] = lh[i] | gh[i];
      bus.lane_nonce_we[i] = (lh[i] && lane_beat[i] == 0) | gn[i];
      bus.lane_hashin_din[i] = lane_beat[i] == 0 ? HASHIN_PAD :
                               {8'(i), 8'(lane_beat[i]), 16'($urandom), 32'($urandom)};
      bus.lane_nonce_din[i] = rnd_nonce ? $urandom : 32'h10 + 32'(i << 8);
    end
    #1;
    hw = bus.lane_hashin_we;
    nw = bus.lane_nonce_we;
    ef = '1;
    if (rst) ef[m_g] = m_frm ? hf : (hf | nf);
    eh = rst && !ef[m_g] && hw[m_g] && (m_frm || nw[m_g]);
    en = eh && !m_frm;
    chk("lane_full", bus.lane_full, ef);
    chk("hin_we", bus.hashin_fifo_in_we, eh);
    chk("hin_din", bus.hashin_fifo_in_din, eh ? bus.lane_hashin_din[m_g] : 64'd0);
    chk("nonce_we", bus.nonce_fifo_we, en);
    chk("nonce_din", bus.nonce_fifo_din, en ? 64'(bus.lane_nonce_din[m_g]) : 64'd0);
    chk("nonce_id", bus.nonce_lane_id, en ? 64'(m_g) : 64'd0);
    chk("proto_err", bus.proto_err, m_err);
    cap_lf = bus.lane_full;
    cap_err = bus.proto_err;
    if (bus.hashin_fifo_in_we) n_hw++;
    if (bus.nonce_fifo_we) begin
      n_nw++;
      last_nonce = bus.nonce_fifo_din;
      last_id = int'(bus.nonce_lane_id);
      order.push_back(last_id);
    end
    if (!rst) begin
      m_g = 0; m_frm = 0; m_beats = 0; m_idle = 0; m_err = '0; m_frames = 0; m_tmos = 0;
      for (int i = 0; i < NL; i++) lane_beat[i] = 0;
    end else begin
      for (int i = 0; i < NL; i++) begin
        if (((hw[i] | nw[i]) && ef[i]) || (i == m_g && (m_frm ? nw[i] : hw[i] != nw[i]))) m_err[i] = 1'b1;
        if (lh[i]) lane_beat[i] = (lane_beat[i] + 1) % FB;
      end
      if (eh) begin
        m_beats++; m_frm = 1; m_idle = 0;
        if (m_beats == FB) begin
          m_frm = 0; m_beats = 0; m_g = (m_g + 1) % NL; m_frames++;
        end
      end else if (!m_frm) begin
        if (hw[m_g] || nw[m_g]) m_idle = 0;
        else if (!(hf || nf)) begin
          m_idle++;
          if (m_idle == TO) begin
            m_idle = 0; m_g = (m_g + 1) % NL; m_tmos++;
          end
        end
      end
    end
    @(posedge clk);
  endtask
  task automatic run(input logic [NL-1:0] want, input int n);
    repeat (n) step(want, '0, '0, 1'b0, 1'b0, 1'b1);
  endtask
  initial begin
    bus.lane_hashin_we = '0;
    bus.lane_nonce_we = '0;
    bus.lane_hashin_din = '0;
    bus.lane_nonce_din = '0;
    bus.hashin_fifo_in_full = 1'b0;
    bus.nonce_fifo_full = 1'b0;
    m_err = '0;
    rnd_nonce = 0;
    repeat (2) @(posedge clk);
    step('0, '0, '0, 0, 0, 0);
    chk("reset_full", cap_lf, 4'hF);
    clr();
    run(4'b0001, 11);
    chk("f0_hin_cnt", n_hw, 11);
    chk("f0_nonce_cnt", n_nw, 1);
    chk("f0_nonce", last_nonce, 32'h10);
    chk("f0_id", last_id, 0);
    clr();
    step(4'b0010, 4'b1000, 4'b1000, 0, 0, 1);
    run(4'b0010, 10);
    step('0, '0, '0, 0, 0, 1);
    chk("l3_err", cap_err, 4'b1000);
    chk("g2_full", cap_lf, 4'b1011);
    chk("l1_cnt", n_hw, 11);
    chk("l1_id", last_id, 1);
    clr();
    run(4'b0100, 6);
    chk("stall_pre", n_hw, 6);
    repeat (5) step(4'b0100, '0, '0, 1, 0, 1);
    chk("stall_hold", n_hw, 6);
    run(4'b0100, 5);
    chk("stall_total", n_hw, 11);
    chk("stall_nonce", n_nw, 1);
    step('0, '0, '0, 0, 0, 0);
    clr();
    run(4'b0001, 5);
    chk("pre_rst_cnt", n_hw, 5);
    step(4'b0001, '0, '0, 0, 0, 0);
    chk("rst_mid_full", cap_lf, 4'hF);
    chk("rst_mid_cnt", n_hw, 5);
    step('0, '0, '0, 0, 0, 1);
    chk("rst_rel_full", cap_lf, 4'b1110);
    step('0, '0, '0, 0, 0, 0);
    clr();
    wait_cyc = -1;
    for (int c = 0; c < 20 && wait_cyc < 0; c++) begin
      step(4'b0100, '0, '0, 0, 0, 1);
      if (n_nw > 0) wait_cyc = c;
    end
    chk("l2_wait", wait_cyc, 8);
    run(4'b0100, 10);
    chk("l2_cnt", n_hw, 11);
    chk("l2_id", last_id, 2);
    step('0, '0, '0, 0, 0, 0);
    clr();
    run(4'hF, 55);
    chk("rr_cnt", n_hw, 55);
    chk("rr_frames", order.size(), 5);
    for (int k = 0; k < 5; k++) chk("rr_order", k < order.size() ? order[k] : -1, k % NL);
    step('0, '0, '0, 0, 0, 0);
    rnd_nonce = 1;
    repeat (1500) step(4'($urandom), '0, '0, $urandom % 6 == 0, $urandom % 6 == 0, 1'b1);
    repeat (400) step(4'($urandom), 4'($urandom & $urandom & $urandom), 4'($urandom & $urandom & $urandom),
                      $urandom % 5 == 0, $urandom % 5 == 0, $urandom % 60 != 0);
`ifdef HASHIN_ARB_STATS_EN
    @(negedge clk);
    chk("frame_cnt", frame_cnt, m_frames);
    chk("timeout_cnt", timeout_cnt, m_tmos);
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
